ysyx_22040759_rf_warb: RTL and testbench
========================================

# ysyx_22040759_rf_warb

Register-file write-port arbiter and long-latency scoreboard for the ysyx_22040759 core. It sits between the write-back stage bus (`ws_to_rf_bus`), the multiply/divide unit (MDU) result port and the single register-file write port. It buffers MDU results in a 2-entry FIFO and gives the WB stage priority, with a starvation guard that briefly stalls WB. It also keeps a 32-bit busy scoreboard that ID uses to stall on registers with pending MDU writes.

## Interface
- `STARVE_MAX`, default 8: number of consecutive cycles a buffered MDU result may lose arbitration before WB is stalled (1..15).
- `clk` input 1: clock.
- `rst` input 1: reset, synchronous, active-high.
- `ws_to_rf_bus` input 70: from WB, {wen[69], waddr[68:64], wdata[63:0]}; wen is already qualified by ws_valid.
- `wb_stall` output 1: WB write not performed this cycle; WB must hold it (feeds ws_ready_go low).
- `mdu_issue_valid` input 1: MDU operation issued this cycle.
- `mdu_issue_rd` input 5: destination of the issued operation.
- `mdu_valid` input 1: MDU result valid.
- `mdu_ready` output 1: FIFO can accept a result.
- `mdu_waddr` input 5: result destination.
- `mdu_wdata` input 64: result data.
- `rf_to_rf_bus` output 70: {wen, waddr, wdata} to the register file.
- `rf_busy` output 32: bit i = register i has a pending MDU write; bit 0 is always 0.

## Operation
- FIFO: 2 entries, with head/tail pointers and a 2-bit count. Push when `mdu_valid && mdu_ready && mdu_waddr!=0`. An `mdu_waddr==0` result is accepted and discarded. Pop when the head is granted.
- `mdu_ready` = count<2 (combinational; 1 after reset). Push and pop in the same cycle while full is not allowed, because ready is 0 when full.
- Request definitions: `wb_req` = wen && waddr!=0. `mdu_req` = FIFO non-empty.
- Starvation counter `starve_cnt`, 4 bits:
  - Cleared on reset, on head grant, or when the FIFO is empty.
  - Otherwise it increments, saturating at STARVE_MAX.
- Grant, evaluated in order each cycle:
  1. `mdu_req && starve_cnt==STARVE_MAX`: grant MDU head. `wb_stall` = `wb_req`.
  2. Else if `wb_req`: grant WB. `wb_stall`=0.
  3. Else if `mdu_req`: grant MDU head.
  4. Else: no write; `rf wen`=0.
- A WB write to x0 is neither forwarded nor stalled.
- Output `rf_to_rf_bus` is combinational from the grant: the WB fields pass through unchanged, or the fields come from the FIFO head.
- Scoreboard:
  - On `mdu_issue_valid && mdu_issue_rd!=0`, set `rf_busy[rd]`.
  - On an MDU-head commit, clear `rf_busy[head.waddr]`.
  - When set and clear hit the same bit in one cycle, set wins.
  - ID never issues a write to a busy rd, so WB and MDU writes to the same register cannot both be outstanding.

## Timing
- Reset state: FIFO empty, `starve_cnt`=0, `rf_busy`=0, `rf wen`=0, `wb_stall`=0, `mdu_ready`=1.
- The WB path is combinational, with 0-cycle latency to the register file.
- MDU result latency without bypass: accepted at edge N, earliest write in cycle N+1.
- Worst-case MDU wait while WB writes every cycle is STARVE_MAX+1 cycles. `wb_stall` lasts exactly 1 cycle, after which `starve_cnt` returns to 0. With 2 entries this gives at most 2 stall cycles per 2·(STARVE_MAX+1) window.
- `rf_busy` bits update at the clock edge. A bit set at edge N is visible in cycle N+1. The bit is cleared at the edge that ends the commit cycle.
- Reset mid-operation: FIFO contents and busy bits are discarded, and no write is issued during the reset cycle.

## Configuration
- `YSYX_22040759_RF_WARB_BYPASS_EN` defined:
  - Condition: FIFO empty, `mdu_valid`, `mdu_waddr!=0`, and `!wb_req`.
  - The result is written the same cycle directly from the inputs, without a push, and its busy bit is cleared.
  - If `wb_req` is active, the result is pushed instead.
- Not defined: every MDU result goes through the FIFO, with minimum latency of 1 cycle.

## Test plan
- WB only: `ws_to_rf_bus`={1,5'd3,64'hA5} -> `rf_to_rf_bus`={1,3,A5} in the same cycle, `wb_stall`=0, `rf_busy`=0.
- MDU idle port: issue rd=7, then result (7,64'h1234) one cycle later -> `rf_busy[7]`=1. The write {1,7,1234} appears in the next cycle, or in the same cycle with BYPASS_EN. `rf_busy[7]` returns to 0 after the commit.
- Starvation with STARVE_MAX=8: WB writes rd=1 every cycle while one MDU result is buffered -> MDU is granted in wait cycle 9, `wb_stall`=1 for that single cycle, and the WB write lands in the next cycle.
- FIFO full: two results pushed during continuous WB writes -> `mdu_ready`=0. A third `mdu_valid` is held until a pop, with no loss or reordering of the results.
- x0 cases: issue rd=0 and result waddr=0 -> no busy bit set and no rf write. A WB write to x0 -> `rf wen`=0.
- Same-cycle set/clear: commit rd=9 while issuing rd=9 -> `rf_busy[9]`=1 afterwards. Assert `rst` with 2 entries buffered -> the FIFO is empty, `rf_busy`=0, and no write occurs.

Source files
------------

// File: rtl/ysyx_22040759_rf_warb.sv
// Register-file write-port arbiter: WB priority, 2-entry MDU result FIFO with starvation guard,
// and busy scoreboard for pending MDU writes. Optional same-cycle bypass: YSYX_22040759_RF_WARB_BYPASS_EN.
module ysyx_22040759_rf_warb #(
  parameter int unsigned STARVE_MAX = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [69:0] ws_to_rf_bus,
  output logic        wb_stall,
  input  logic        mdu_issue_valid,
  input  logic [4:0]  mdu_issue_rd,
  input  logic        mdu_valid,
  output logic        mdu_ready,
  input  logic [4:0]  mdu_waddr,
  input  logic [63:0] mdu_wdata,
  output logic [69:0] rf_to_rf_bus,
  output logic [31:0] rf_busy
);

  localparam int unsigned AW = 5;
  localparam int unsigned DW = 64;
  localparam int unsigned CW = 4;
  localparam logic [CW-1:0] STARVE_LIM = CW'(STARVE_MAX);

  logic [AW-1:0] q_addr [2];
  logic [DW-1:0] q_data [2];
  logic          head;
  logic          tail;
  logic [1:0]    count;
  logic [CW-1:0] starve_cnt;

  logic          wb_req;
  logic          mdu_req;
  logic          starved;
  logic          grant_mdu;
  logic          bypass;
  logic          push;
  logic [31:0]   busy_set;
  logic [31:0]   busy_clr;
  logic [31:0]   busy_next;

  assign mdu_ready = (count < 2'd2);
  assign push      = mdu_valid && mdu_ready && (mdu_waddr != '0) && !bypass;

  // Grant selection; nothing is written while reset is asserted.
  always_comb begin
    wb_req       = ws_to_rf_bus[69] && (ws_to_rf_bus[68:64] != '0);
    mdu_req      = (count != 2'd0);
    starved      = mdu_req && (starve_cnt == STARVE_LIM);
    grant_mdu    = 1'b0;
    bypass       = 1'b0;
    wb_stall     = 1'b0;
    rf_to_rf_bus = '0;
    if (!rst) begin
      if (starved) begin
        grant_mdu = 1'b1;
        wb_stall  = wb_req;
      end else if (wb_req) begin
        rf_to_rf_bus = ws_to_rf_bus;
      end else if (mdu_req) begin
        grant_mdu = 1'b1;
`ifdef YSYX_22040759_RF_WARB_BYPASS_EN
      end else if (mdu_valid && (mdu_waddr != '0)) begin
        bypass = 1'b1;
`endif
      end
      if (grant_mdu) rf_to_rf_bus = {1'b1, q_addr[head], q_data[head]};
      if (bypass)    rf_to_rf_bus = {1'b1, mdu_waddr, mdu_wdata};
    end
  end

  // Scoreboard: a new issue wins over a same-cycle commit to the same register.
  always_comb begin
    busy_set     = 32'(mdu_issue_valid) << mdu_issue_rd;
    busy_clr     = (32'(grant_mdu) << q_addr[head]) | (32'(bypass) << mdu_waddr);
    busy_next    = (rf_busy & ~busy_clr) | busy_set;
    busy_next[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      head       <= 1'b0;
      tail       <= 1'b0;
      count      <= 2'd0;
      starve_cnt <= '0;
      rf_busy    <= '0;
    end else begin
      if (push) begin
        q_addr[tail] <= mdu_waddr;
        q_data[tail] <= mdu_wdata;
        tail         <= ~tail;
      end
      if (grant_mdu) head <= ~head;
      count <= count + 2'(push) - 2'(grant_mdu);
      if (grant_mdu || !mdu_req)       starve_cnt <= '0;
      else if (starve_cnt < STARVE_LIM) starve_cnt <= starve_cnt + CW'(1);
      rf_busy <= busy_next;
    end
  end

endmodule

// File: tb/tb_ysyx_22040759_rf_warb.sv
// Bench for ysyx_22040759_rf_warb: directed scenarios plus random traffic against a queue-based model.
module tb_ysyx_22040759_rf_warb;

  localparam int unsigned SM = 8;
`ifdef YSYX_22040759_RF_WARB_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic [69:0] ws;
  logic        wb_stall;
  logic        iv_s;
  logic [4:0]  ird_s;
  logic        mv_s;
  logic        mdu_ready;
  logic [4:0]  ma_s;
  logic [63:0] md_s;
  logic [69:0] rf_bus;
  logic [31:0] rf_busy;

  always #5 clk = ~clk;

  ysyx_22040759_rf_warb #(.STARVE_MAX(SM)) dut (
    .clk(clk), .rst(rst), .ws_to_rf_bus(ws), .wb_stall(wb_stall),
    .mdu_issue_valid(iv_s), .mdu_issue_rd(ird_s), .mdu_valid(mv_s),
    .mdu_ready(mdu_ready), .mdu_waddr(ma_s), .mdu_wdata(md_s),
    .rf_to_rf_bus(rf_bus), .rf_busy(rf_busy)
  );

  int n_vec = 0;
  int n_err = 0;

  // Model: pending results in arrival order, busy registers, cycles the head has lost.
  logic [69:0] mq[$];
  logic [31:0] busy_m = '0;
  int          wait_m = 0;
  logic [69:0] exp_bus;
  logic        exp_stall;
  logic        exp_ready;
  logic        acc;

  localparam logic [69:0] IDLE = '0;

  function automatic logic [69:0] wbw(input logic [4:0] a, input logic [63:0] d);
    return {1'b1, a, d};
  endfunction

  task automatic chk(input string tag, input logic [69:0] obs, input logic [69:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic step(input logic [69:0] wb, input logic iv, input logic [4:0] ird,
                      input logic mv, input logic [4:0] ma, input logic [63:0] md,
                      input logic r);
    logic        wbreq;
    logic        mreq;
    logic        pop_f;
    logic        byp_f;
    logic [69:0] tmp;
    ws = wb; iv_s = iv; ird_s = ird; mv_s = mv; ma_s = ma; md_s = md; rst = r;
    #3;
    pop_f     = 1'b0;
    byp_f     = 1'b0;
    wbreq     = wb[69] && (wb[68:64] != '0);
    mreq      = (mq.size() != 0);
    exp_ready = (mq.size() < 2);
    exp_stall = 1'b0;
    exp_bus   = '0;
    acc       = 1'b0;
    if (!r) begin
      if (mreq && wait_m == int'(SM)) begin
        exp_bus = mq[0]; exp_stall = wbreq; pop_f = 1'b1;
      end else if (wbreq) begin
        exp_bus = wb;
      end else if (mreq) begin
        exp_bus = mq[0]; pop_f = 1'b1;
      end else if (BYP && mv && ma != '0) begin
        exp_bus = {1'b1, ma, md}; byp_f = 1'b1;
      end
    end
    chk("rf_bus", rf_bus, exp_bus);
    chk("wb_stall", 70'(wb_stall), 70'(exp_stall));
    chk("mdu_ready", 70'(mdu_ready), 70'(exp_ready));
    chk("rf_busy", 70'(rf_busy), 70'(busy_m));
    if (r) begin
      mq.delete();
      busy_m = '0;
      wait_m = 0;
    end else begin
      acc = mv && exp_ready;
      if (pop_f) begin
        tmp = mq.pop_front();
        busy_m[tmp[68:64]] = 1'b0;
      end
      if (byp_f) busy_m[ma] = 1'b0;
      if (acc && ma != '0 && !byp_f) mq.push_back({1'b1, ma, md});
      if (iv && ird != '0) busy_m[ird] = 1'b1;
      if (pop_f || !mreq) wait_m = 0;
      else if (wait_m < int'(SM)) wait_m = wait_m + 1;
    end
  endtask

  initial begin
    logic [63:0] d;
    logic [4:0]  ra [3];
    logic [63:0] rd [3];
    int          idx;
    logic        pv;
    logic [4:0]  pa;
    logic [63:0] pd;
    logic [69:0] wbv;
    logic        hold;
    logic        r;

    rst = 1'b1; ws = '0; iv_s = 0; ird_s = '0; mv_s = 0; ma_s = '0; md_s = '0;
    tick();

    // Reset state
    step(IDLE, 0, 0, 0, 0, 0, 0);
    chk("reset_bus", rf_bus, IDLE);
    chk("reset_ready", 70'(mdu_ready), 70'(1));
    chk("reset_busy", 70'(rf_busy), 70'(0));
    tick();

    // WB-only pass-through
    step(wbw(5'd3, 64'hA5), 0, 0, 0, 0, 0, 0);
    chk("wb_only_bus", rf_bus, {1'b1, 5'd3, 64'hA5});
    chk("wb_only_stall", 70'(wb_stall), 70'(0));
    tick();

    // MDU on an idle port
    step(IDLE, 1, 5'd7, 0, 0, 0, 0);
    tick();
    step(IDLE, 0, 0, 1, 5'd7, 64'h1234, 0);
    chk("idle_busy7_set", 70'(rf_busy[7]), 70'(1));
`ifdef YSYX_22040759_RF_WARB_BYPASS_EN
    chk("idle_bypass_bus", rf_bus, {1'b1, 5'd7, 64'h1234});
`else
    chk("idle_accept_bus", rf_bus, IDLE);
`endif
    tick();
    step(IDLE, 0, 0, 0, 0, 0, 0);
`ifndef YSYX_22040759_RF_WARB_BYPASS_EN
    chk("idle_commit_bus", rf_bus, {1'b1, 5'd7, 64'h1234});
`endif
    tick();
    step(IDLE, 0, 0, 0, 0, 0, 0);
    chk("idle_busy7_clr", 70'(rf_busy[7]), 70'(0));
    tick();

    // Starvation: WB writes x1 every cycle while one result waits
    d = 64'd100;
    step(IDLE, 1, 5'd5, 0, 0, 0, 0);
    tick();
    step(wbw(5'd1, d), 0, 0, 1, 5'd5, 64'h55, 0);
    d++;
    tick();
    for (int k = 1; k <= 10; k++) begin
      step(wbw(5'd1, d), 0, 0, 0, 0, 0, 0);
      if (k == 9) begin
        chk("starve_stall", 70'(wb_stall), 70'(1));
        chk("starve_grant", rf_bus, {1'b1, 5'd5, 64'h55});
      end else if (k == 10) begin
        chk("starve_wb_lands", rf_bus, wbw(5'd1, d));
      end else begin
        chk("starve_no_stall", 70'(wb_stall), 70'(0));
      end
      if (!exp_stall) d++;
      tick();
    end

    // FIFO full under continuous WB; third result held until a pop
    ra[0] = 5'd10; ra[1] = 5'd11; ra[2] = 5'd12;
    rd[0] = 64'hA; rd[1] = 64'hB; rd[2] = 64'hC;
    idx = 0;
    for (int c = 0; c < 60 && idx < 3; c++) begin
      step(wbw(5'd2, 64'(c)), 0, 0, 1, ra[idx], rd[idx], 0);
      if (c == 2) chk("fifo_full_ready", 70'(mdu_ready), 70'(0));
      if (acc) idx++;
      tick();
    end
    chk("fifo_third_accepted", 70'(idx), 70'(3));
    for (int c = 0; c < 10 && mq.size() != 0; c++) begin
      step(IDLE, 0, 0, 0, 0, 0, 0);
      tick();
    end
    chk("fifo_drained", 70'(mq.size()), 70'(0));

    // x0 cases
    step(IDLE, 1, 5'd0, 1, 5'd0, 64'hDEAD, 0);
    chk("x0_mdu_bus", rf_bus, IDLE);
    tick();
    step(wbw(5'd0, 64'h77), 0, 0, 0, 0, 0, 0);
    chk("x0_wb_wen", 70'(rf_bus[69]), 70'(0));
    chk("x0_wb_stall", 70'(wb_stall), 70'(0));
    chk("x0_busy", 70'(rf_busy), 70'(0));
    tick();

    // Commit rd=9 while issuing rd=9
    step(IDLE, 1, 5'd9, 0, 0, 0, 0);
    tick();
    step(IDLE, BYP, 5'd9, 1, 5'd9, 64'h99, 0);
    tick();
    step(IDLE, !BYP, 5'd9, 0, 0, 0, 0);
    tick();
    step(IDLE, 0, 0, 0, 0, 0, 0);
    chk("setclr_busy9", 70'(rf_busy[9]), 70'(1));
    tick();

    // Reset with two entries buffered
    step(wbw(5'd2, 64'd1), 1, 5'd13, 1, 5'd13, 64'h13, 0);
    tick();
    step(wbw(5'd2, 64'd2), 1, 5'd14, 1, 5'd14, 64'h14, 0);
    tick();
    step(wbw(5'd2, 64'd3), 0, 0, 0, 0, 0, 1);
    chk("rst_no_write", rf_bus, IDLE);
    chk("rst_no_stall", 70'(wb_stall), 70'(0));
    tick();
    step(IDLE, 0, 0, 0, 0, 0, 0);
    chk("rst_after_bus", rf_bus, IDLE);
    chk("rst_after_busy", 70'(rf_busy), 70'(0));
    chk("rst_after_ready", 70'(mdu_ready), 70'(1));
    tick();

    // Random traffic
    pv = 1'b0; pa = '0; pd = '0; hold = 1'b0; wbv = '0;
    for (int i = 0; i < 800; i++) begin
      if (!pv && ($urandom % 3) == 0) begin
        pv = 1'b1;
        pa = (($urandom % 8) == 0) ? 5'd0 : 5'($urandom);
        pd = {$urandom, $urandom};
      end
      if (!hold) wbv = {($urandom % 4) != 0, 5'($urandom), $urandom, $urandom};
      r = (($urandom % 200) == 0);
      step(wbv, ($urandom % 3) == 0, 5'($urandom), pv, pa, pd, r);
      if (acc) pv = 1'b0;
      hold = exp_stall;
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
